// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types, encodings and access-size helpers for the memory-stage controller.
package mem_stage_ctrl_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int INSTR_TYPE_SZ   = 2;
    localparam int ROB_ENTRY_WIDTH = 3;
    localparam int BE_W            = WORD_SIZE / 8;

    localparam logic [INSTR_TYPE_SZ-1:0] ITYPE_ALU   = 2'd0;
    localparam logic [INSTR_TYPE_SZ-1:0] ITYPE_LOAD  = 2'd1;
    localparam logic [INSTR_TYPE_SZ-1:0] ITYPE_STORE = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Unlisted funct3 codes fall back to a full-word access.
    function automatic acc_size_t access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (access_size(f3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (access_size(f3))
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data across lanes lets the byte enables pick the target lane.
    function automatic logic [WORD_SIZE-1:0] store_data(input logic [2:0] f3, input logic [WORD_SIZE-1:0] s2);
        case (access_size(f3))
            SZ_BYTE: return {4{s2[7:0]}};
            SZ_HALF: return {2{s2[15:0]}};
            default: return s2;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bundle of E->M inputs, data-memory handshake and writeback result signals.
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;

    logic                       valid;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic [2:0]                 funct3;
    logic [WORD_SIZE-1:0]       aluResult;
    logic [WORD_SIZE-1:0]       s2;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    logic                       stall;

    logic                       mem_req;
    logic                       mem_we;
    logic [WORD_SIZE-1:0]       mem_addr;
    logic [BE_W-1:0]            mem_be;
    logic [WORD_SIZE-1:0]       mem_wdata;
    logic                       mem_ack;
    logic [WORD_SIZE-1:0]       mem_rdata;

    logic                       wb_valid;
    logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id;
    logic [WORD_SIZE-1:0]       wb_pc;
    logic [WORD_SIZE-1:0]       wb_value;
    logic                       wb_exception;

    modport master (
        input  valid, instruction_type, pc, funct3, aluResult, s2, rob_id,
        input  mem_ack, mem_rdata,
        output stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rob_id, wb_pc, wb_value, wb_exception
    );

    modport slave (
        output valid, instruction_type, pc, funct3, aluResult, s2, rob_id,
        output mem_ack, mem_rdata,
        input  stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rob_id, wb_pc, wb_value, wb_exception
    );

endinterface

// File: rtl/mem_stage_ctrl_load_align_ext.sv
// Selects the addressed lane of a read word and sign/zero-extends it per funct3.
module load_align_ext
    import mem_stage_ctrl_pkg::*;
(
    input  logic [WORD_SIZE-1:0] rdata_i,
    input  logic [1:0]           offset_i,
    input  logic [2:0]           funct3_i,
    output logic [WORD_SIZE-1:0] value_o
);

    logic [WORD_SIZE-1:0] shifted;

    // Shift the addressed byte lane down to bit 0, then extend by access size.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (access_size(funct3_i))
            SZ_BYTE: value_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: value_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: value_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-memory requests, stalls upstream while a
// request is outstanding, and returns one tagged result per instruction.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_stage_ctrl_if.master  bus
);

    state_t                     state_q, state_d;
    logic [2:0]                 f3_q, f3_d;
    logic [1:0]                 off_q, off_d;
    logic [ROB_ENTRY_WIDTH-1:0] rob_q, rob_d;
    logic [WORD_SIZE-1:0]       pc_q, pc_d;

    logic                       mem_req_q, mem_req_d;
    logic                       mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0]       mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]            mem_be_q, mem_be_d;
    logic [WORD_SIZE-1:0]       mem_wdata_q, mem_wdata_d;

    logic                       wb_valid_q, wb_valid_d;
    logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id_q, wb_rob_id_d;
    logic [WORD_SIZE-1:0]       wb_pc_q, wb_pc_d;
    logic [WORD_SIZE-1:0]       wb_value_q, wb_value_d;
    logic                       wb_exception_q, wb_exception_d;

    logic                       stall;
    logic                       is_mem;
    logic                       mis;
    logic [WORD_SIZE-1:0]       load_value;

    assign is_mem = (bus.instruction_type == ITYPE_LOAD) || (bus.instruction_type == ITYPE_STORE);
    assign mis    = misaligned(bus.funct3, bus.aluResult[1:0]);

    load_align_ext u_align (
        .rdata_i  (bus.mem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .value_o  (load_value)
    );

    // State and all registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            f3_q           <= '0;
            off_q          <= '0;
            rob_q          <= '0;
            pc_q           <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_rob_id_q    <= '0;
            wb_pc_q        <= '0;
            wb_value_q     <= '0;
            wb_exception_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            f3_q           <= f3_d;
            off_q          <= off_d;
            rob_q          <= rob_d;
            pc_q           <= pc_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_rob_id_q    <= wb_rob_id_d;
            wb_pc_q        <= wb_pc_d;
            wb_value_q     <= wb_value_d;
            wb_exception_q <= wb_exception_d;
        end
    end

    // Only aligned loads/stores leave IDLE; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.valid && is_mem && !mis) state_d = ST_REQ;
            ST_REQ:  if (bus.mem_ack) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall plus next values of the memory-side and writeback-side registers.
    always_comb begin
        stall          = 1'b0;
        f3_d           = f3_q;
        off_d          = off_q;
        rob_d          = rob_q;
        pc_d           = pc_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_rob_id_d    = wb_rob_id_q;
        wb_pc_d        = wb_pc_q;
        wb_value_d     = wb_value_q;
        wb_exception_d = wb_exception_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_value_d     = bus.aluResult;
                        wb_exception_d = 1'b0;
                        wb_rob_id_d    = bus.rob_id;
                        wb_pc_d        = bus.pc;
                    end else if (mis) begin
                        wb_valid_d     = 1'b1;
                        wb_value_d     = '0;
                        wb_exception_d = 1'b1;
                        wb_rob_id_d    = bus.rob_id;
                        wb_pc_d        = bus.pc;
                    end else begin
                        stall       = 1'b1;
                        f3_d        = bus.funct3;
                        off_d       = bus.aluResult[1:0];
                        rob_d       = bus.rob_id;
                        pc_d        = bus.pc;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (bus.instruction_type == ITYPE_STORE);
                        mem_addr_d  = {bus.aluResult[WORD_SIZE-1:2], 2'b00};
                        mem_be_d    = byte_enables(bus.funct3, bus.aluResult[1:0]);
                        mem_wdata_d = store_data(bus.funct3, bus.s2);
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus.mem_ack) begin
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_be_d       = '0;
                    wb_valid_d     = 1'b1;
                    wb_value_d     = mem_we_q ? '0 : load_value;
                    wb_exception_d = 1'b0;
                    wb_rob_id_d    = rob_q;
                    wb_pc_d        = pc_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.stall        = stall;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rob_id    = wb_rob_id_q;
    assign bus.wb_pc        = wb_pc_q;
    assign bus.wb_value     = wb_value_q;
    assign bus.wb_exception = wb_exception_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed and randomized bench for mem_stage_ctrl with a byte-level reference model.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes.
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        int n = size_of(f3);
        int be = ((1 << n) - 1) << off;
        return 4'(be);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] s2_v);
        int n = size_of(f3);
        if (n == 1) return (s2_v & 32'h0000_00FF) * 32'h0101_0101;
        if (n == 2) return (s2_v & 32'h0000_FFFF) * 32'h0001_0001;
        return s2_v;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
        int n = size_of(f3);
        logic [31:0] v;
        logic [31:0] mask;
        v = rdata >> (8 * int'(off));
        if (n == 4) return v;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // Presents one instruction at a negedge with the DUT idle and follows it to its result.
    task automatic run_instr(input string tag, input logic [1:0] ty, input logic [31:0] pc_v,
                             input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] s2_v,
                             input logic [2:0] rob, input int ack_dly, input logic [31:0] rdata,
                             output logic [31:0] got_value, output logic [3:0] got_be);
        bit mem_op, store, mis;
        int n;
        logic [31:0] exp_val;
        n      = size_of(f3);
        mem_op = (ty == ITYPE_LOAD) || (ty == ITYPE_STORE);
        store  = (ty == ITYPE_STORE);
        mis    = mem_op && ((addr % n) != 0);
        got_be = '0;
        bus.valid            = 1'b1;
        bus.instruction_type = ty;
        bus.pc               = pc_v;
        bus.funct3           = f3;
        bus.aluResult        = addr;
        bus.s2               = s2_v;
        bus.rob_id           = rob;
        bus.mem_ack          = 1'b0;
        #1;
        check({tag, ".stall_accept"}, 32'(bus.stall), 32'(mem_op && !mis));
        if (!mem_op || mis) begin
            @(negedge clk);
            exp_val = mis ? 32'h0 : addr;
            check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'h1);
            check({tag, ".wb_value"}, bus.wb_value, exp_val);
            check({tag, ".wb_exc"}, 32'(bus.wb_exception), 32'(mis));
            check({tag, ".wb_rob"}, 32'(bus.wb_rob_id), 32'(rob));
            check({tag, ".wb_pc"}, bus.wb_pc, pc_v);
            check({tag, ".no_req"}, 32'(bus.mem_req), 32'h0);
            got_value = bus.wb_value;
        end else begin
            @(negedge clk);
            for (int k = 0; k <= ack_dly; k++) begin
                check({tag, ".req"}, 32'(bus.mem_req), 32'h1);
                check({tag, ".we"}, 32'(bus.mem_we), 32'(store));
                check({tag, ".addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                check({tag, ".be"}, 32'(bus.mem_be), 32'(m_be(f3, addr[1:0])));
                if (store) check({tag, ".wdata"}, bus.mem_wdata, m_wdata(f3, s2_v));
                check({tag, ".stall_req"}, 32'(bus.stall), 32'h1);
                check({tag, ".wb_quiet"}, 32'(bus.wb_valid), 32'h0);
                if (k == 0) got_be = bus.mem_be;
                if (k == ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end else begin
                    bus.mem_rdata = $urandom;
                end
                @(negedge clk);
            end
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            exp_val = store ? 32'h0 : m_load(f3, addr[1:0], rdata);
            check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'h1);
            check({tag, ".wb_value"}, bus.wb_value, exp_val);
            check({tag, ".wb_exc"}, 32'(bus.wb_exception), 32'h0);
            check({tag, ".wb_rob"}, 32'(bus.wb_rob_id), 32'(rob));
            check({tag, ".wb_pc"}, bus.wb_pc, pc_v);
            check({tag, ".req_drop"}, 32'(bus.mem_req), 32'h0);
            check({tag, ".stall_done"}, 32'(bus.stall), 32'h0);
            got_value = bus.wb_value;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            check({tag, ".done_ignored_wb"}, 32'(bus.wb_valid), 32'h0);
            check({tag, ".done_ignored_req"}, 32'(bus.mem_req), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [3:0]  be;
        bus.valid            = 1'b0;
        bus.instruction_type = '0;
        bus.pc               = '0;
        bus.funct3           = '0;
        bus.aluResult        = '0;
        bus.s2               = '0;
        bus.rob_id           = '0;
        bus.mem_ack          = 1'b0;
        bus.mem_rdata        = '0;

        #1 reset = 1'b1;
        #1;
        check("rst.req", 32'(bus.mem_req), 32'h0);
        check("rst.we", 32'(bus.mem_we), 32'h0);
        check("rst.be", 32'(bus.mem_be), 32'h0);
        check("rst.wb_valid", 32'(bus.wb_valid), 32'h0);
        check("rst.wb_exc", 32'(bus.wb_exception), 32'h0);
        check("rst.wb_value", bus.wb_value, 32'h0);
        check("rst.wb_pc", bus.wb_pc, 32'h0);
        check("rst.wb_rob", 32'(bus.wb_rob_id), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_instr("alu", ITYPE_ALU, 32'h100, 3'b000, 32'd7, 32'h0, 3'd2, 0, 32'h0, v, be);
        check("alu.value_lit", v, 32'd7);

        run_instr("lb", ITYPE_LOAD, 32'h104, 3'b000, 32'h0000_1003, 32'h0, 3'd3, 0, 32'h80FF_FFFF, v, be);
        check("lb.be_lit", 32'(be), 32'h8);
        check("lb.value_lit", v, 32'hFFFF_FF80);

        run_instr("sh", ITYPE_STORE, 32'h108, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3'd4, 3, 32'h0, v, be);
        check("sh.be_lit", 32'(be), 32'hC);
        check("sh.value_lit", v, 32'h0);

        run_instr("mis_lw", ITYPE_LOAD, 32'h10C, 3'b010, 32'h0000_0001, 32'h0, 3'd5, 0, 32'h0, v, be);

        // Reset while a request is outstanding, then a stale ack.
        run_instr("pre_rst", ITYPE_ALU, 32'h110, 3'b000, 32'h55, 32'h0, 3'd1, 0, 32'h0, v, be);
        bus.instruction_type = ITYPE_LOAD;
        bus.funct3           = 3'b010;
        bus.aluResult        = 32'h0000_0040;
        bus.rob_id           = 3'd6;
        @(negedge clk);
        check("rreq.req", 32'(bus.mem_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rreq.req_clr", 32'(bus.mem_req), 32'h0);
        check("rreq.be_clr", 32'(bus.mem_be), 32'h0);
        check("rreq.wb_valid_clr", 32'(bus.wb_valid), 32'h0);
        check("rreq.wb_pc_clr", bus.wb_pc, 32'h0);
        bus.valid = 1'b0;
        #1;
        check("rreq.idle_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack.wb_valid", 32'(bus.wb_valid), 32'h0);
            check("late_ack.req", 32'(bus.mem_req), 32'h0);
            @(negedge clk);
        end

        // Idle bus with junk fields.
        for (int i = 0; i < 4; i++) begin
            bus.valid            = 1'b0;
            bus.instruction_type = 2'($urandom_range(0, 2));
            bus.funct3           = 3'($urandom);
            bus.aluResult        = $urandom;
            bus.s2               = $urandom;
            #1;
            check("idle.stall", 32'(bus.stall), 32'h0);
            @(negedge clk);
            check("idle.req", 32'(bus.mem_req), 32'h0);
            check("idle.wb_valid", 32'(bus.wb_valid), 32'h0);
        end

        for (int i = 0; i < 80; i++) begin
            run_instr("rand", 2'($urandom_range(0, 2)), $urandom, 3'($urandom_range(0, 7)), $urandom,
                      $urandom, 3'($urandom), int'($urandom_range(0, 3)), $urandom, v, be);
        end

        bus.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller that consumes the Execute->Memory pipeline-register outputs and drives a single-port data memory (req/ack handshake).
- Generates the `stall` that freezes the E->M register and all upstream stages.
- Aligns and extends load data, and delivers one result per instruction, tagged with rob_id, to the writeback/ROB side.

Parameters:
- WORD_SIZE, 32, data/address width (only 32 supported).
- INSTR_TYPE_SZ, 2, width of instruction_type.
- ROB_ENTRY_WIDTH, 3, width of rob_id.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- valid  in  1  E->M entry holds a live instruction.
- instruction_type  in  INSTR_TYPE_SZ  ALU / LOAD / STORE (package encoding).
- pc  in  WORD_SIZE  instruction PC.
- funct3  in  3  RISC-V access size/sign.
- aluResult  in  WORD_SIZE  ALU result, or effective address for LOAD/STORE.
- s2  in  WORD_SIZE  store data.
- rob_id  in  ROB_ENTRY_WIDTH  ROB tag.
- stall  out  1  hold E->M register and upstream.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write.
- mem_addr  out  WORD_SIZE  word-aligned address (bits[1:0]=0).
- mem_be  out  WORD_SIZE/8  byte enables.
- mem_wdata  out  WORD_SIZE  lane-shifted store data.
- mem_ack  in  1  request accepted/completed this cycle; mem_rdata valid with it.
- mem_rdata  in  WORD_SIZE  read word.
- wb_valid  out  1  result pulse, one cycle per instruction.
- wb_rob_id  out  ROB_ENTRY_WIDTH  tag of result.
- wb_pc  out  WORD_SIZE  PC of result.
- wb_value  out  WORD_SIZE  result (0 for stores).
- wb_exception  out  1  misaligned access.

Behaviour:
- Reset (async, any time):
  - state=IDLE; mem_req=0, mem_we=0, mem_be=0.
  - wb_valid=0, wb_exception=0; wb_value, wb_pc and wb_rob_id all 0.
  - A mem_ack arriving after reset is ignored.
- All wb_* outputs and mem_* outputs are registered. stall is combinational.
- FSM states: IDLE, REQ, DONE. New instructions are accepted only in IDLE.
- IDLE, valid=0: wb_valid=0 next cycle; stall=0.
- IDLE, valid & ALU: next cycle wb_valid=1, wb_value=aluResult, wb_exception=0; stall=0; stay IDLE (one instruction per cycle).
- IDLE, valid & LOAD/STORE & misaligned:
  - Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
  - Next cycle wb_valid=1, wb_exception=1, wb_value=0; no mem_req; stall=0; stay IDLE.
- IDLE, valid & LOAD/STORE & aligned:
  - stall=1 this cycle.
  - Latch funct3, addr[1:0], rob_id and pc.
  - Drive mem_req=1, mem_addr, mem_we, mem_be and mem_wdata from the next edge; go to REQ.
- REQ:
  - stall=1; mem_* held stable until mem_ack.
  - On mem_ack: mem_req=0 next cycle, capture the aligned/extended result, go to DONE.
- DONE:
  - wb_valid=1 with the captured result; stall=0, so the E->M register advances at this edge.
  - The E->M contents visible during DONE are the already-serviced instruction and are ignored; go to IDLE.
  - Minimum memory-op latency: accept cycle -> wb_valid 2 cycles later when mem_ack arrives in the first REQ cycle.
- Byte enables and store data (o=addr[1:0]):
  - SB (000): be=0001<<o, wdata=s2[7:0] replicated in all lanes.
  - SH (001): be=0011<<o, wdata={2{s2[15:0]}}.
  - SW (010): be=1111, wdata=s2.
- Loads take the selected lane of mem_rdata:
  - LB 000 sign-extends a byte; LBU 100 zero-extends a byte.
  - LH 001 sign-extends a halfword; LHU 101 zero-extends a halfword.
  - LW 010 uses the full word.
  - Loads set be per size, as for stores.
- Any other funct3 for LOAD/STORE: treat as LW/SW.
- Stores report wb_valid with wb_value=0 so the ROB can retire them.
- mem_ack while in IDLE or DONE: ignored.

Decomposition:
- Shared package holds:
  - instruction-type encodings (ITYPE_ALU=0, ITYPE_LOAD=1, ITYPE_STORE=2);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state enum.
- One natural sub-module: load_align_ext, a combinational block taking rdata, offset and funct3 and returning the extended value.

Test Plan:
- ALU pass-through: valid=1, type=ALU, aluResult=7, rob_id=2 -> next cycle wb_valid=1, wb_value=7, wb_rob_id=2; stall stays 0.
- LB sign-extend: address 0x1003, funct3=000, mem_ack in first REQ cycle with rdata=0x80FF_FFFF.
  - mem_addr=0x1000, be=1000.
  - stall=1 for 2 cycles.
  - wb_value=0xFFFF_FF80 two cycles after accept.
- SH at 0x2002, s2=0x1234ABCD, ack delayed 3 cycles:
  - mem_we=1, be=1100, wdata=0xABCD_ABCD, held stable until ack.
  - wb_valid=1, wb_value=0.
- Misaligned LW at 0x0001 -> next cycle wb_valid=1, wb_exception=1; mem_req never asserted; stall=0.
- Reset asserted in REQ, mem_ack arriving 1 cycle later:
  - Outputs clear immediately and state is IDLE.
  - The late ack produces no wb_valid.
- valid=0 with arbitrary fields -> mem_req=0, wb_valid=0, stall=0 for 4 cycles.
